// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the serial sequence detector.
// Words stream back-to-back with sof/eof strobes on first/last bit.
module piso_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              x,
  output logic              x_valid,
  output logic              sof,
  output logic              eof
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic [0:0]        state;
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     bit_cnt;
  logic              last;
  logic              xfer;

  function automatic logic head(input logic [DATA_W-1:0] v);
    head = MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] adv(
    input logic [DATA_W-1:0] v
  );
    adv = MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  assign last     = (state == SHIFT) && (bit_cnt == LAST);
  assign in_ready = reset_n && ((state == IDLE) || last);
  assign xfer     = in_valid && in_ready;

  // x holds the current bit; sreg holds the bits still to come
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      sof     <= 1'b0;
      eof     <= 1'b0;
    end else if (xfer) begin
      state   <= SHIFT;
      sreg    <= adv(in_data);
      bit_cnt <= '0;
      x       <= head(in_data);
      x_valid <= 1'b1;
      sof     <= 1'b1;
      eof     <= 1'b0;
    end else if ((state == SHIFT) && !last) begin
      sreg    <= adv(sreg);
      bit_cnt <= bit_cnt + CW'(1);
      x       <= head(sreg);
      sof     <= 1'b0;
      eof     <= ((bit_cnt + CW'(1)) == LAST);
    end else begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      sof     <= 1'b0;
      eof     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first
// instances share one input stream and one expected-bit queue.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic rdy_m, x_m, xv_m, sof_m, eof_m;
  logic rdy_l, x_l, xv_l, sof_l, eof_l;

  typedef struct packed {
    logic xm;
    logic xl;
    logic s;
    logic e;
  } ent_t;

  ent_t q[$];
  ent_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   run = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_m), .x(x_m), .x_valid(xv_m),
    .sof(sof_m), .eof(eof_m)
  );

  piso_serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_l), .x(x_l), .x_valid(xv_l),
    .sof(sof_l), .eof(eof_l)
  );

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time,
               act, exp);
    end
  endtask

  // model: reset flushes, a transfer queues the word's bits
  always @(posedge clk) begin
    if (!reset_n) begin
      q.delete();
    end else if (in_valid && rdy_m) begin
      for (int i = 0; i < W; i++) begin
        ent_t e;
        e.xm = in_data[W-1-i];
        e.xl = in_data[i];
        e.s  = (i == 0);
        e.e  = (i == W - 1);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("in_ready_msb", rdy_m, reset_n && (q.size() <= 1));
      chk("in_ready_lsb", rdy_l, reset_n && (q.size() <= 1));
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("x_valid_msb", xv_m, 1'b1);
        chk("x_valid_lsb", xv_l, 1'b1);
        chk("x_msb", x_m, mon_e.xm);
        chk("x_lsb", x_l, mon_e.xl);
        chk("sof_msb", sof_m, mon_e.s);
        chk("sof_lsb", sof_l, mon_e.s);
        chk("eof_msb", eof_m, mon_e.e);
        chk("eof_lsb", eof_l, mon_e.e);
      end else begin
        chk("idle_xv_msb", xv_m, 1'b0);
        chk("idle_xv_lsb", xv_l, 1'b0);
        chk("idle_x_msb", x_m, 1'b0);
        chk("idle_x_lsb", x_l, 1'b0);
        chk("idle_sof", sof_m | sof_l, 1'b0);
        chk("idle_eof", eof_m | eof_l, 1'b0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // offer a word; jitter scrambles in_data while stalled
  task automatic put(input logic [W-1:0] w, input bit jitter);
    int  n;
    bit  acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      acc = rdy_m;
      tick();
      if (acc) break;
      if (jitter) in_data = W'($urandom);
      n++;
      if (n > 4 * W) begin
        n_chk++;
        n_fail++;
        $display("FAIL put_timeout t=%0t", $time);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 4 * W) begin
      tick();
      n++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
  endtask

  initial begin
    run = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (20) tick();

    put(8'hB0, 1'b0);
    drain();
    repeat (2) tick();

    put(8'h05, 1'b0);
    put(8'hB5, 1'b0);
    drain();

    put(8'h0D, 1'b0);
    drain();
    tick();

    // stall: request arrives mid-word with changing data
    put(8'hA5, 1'b0);
    repeat (3) tick();
    put(8'h3C, 1'b1);
    drain();

    // reset during bit 4
    put(8'hFF, 1'b0);
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    put(8'h96, 1'b0);
    drain();

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        put(W'($urandom), 1'(($urandom_range(0, 1))));
      end else begin
        repeat ($urandom_range(1, 10)) tick();
      end
      if ($urandom_range(0, 60) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end
    end
    drain();
    repeat (3) tick();
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
